// File: rtl/lvds_sched_pkg.sv
// Shared state encoding, marker position, default idle payload and width helper
// for the LVDS lane scheduler.
package lvds_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    LAST = 2'd2
  } state_t;

  localparam int         MARK_BIT      = 0;
  localparam logic [4:0] DEF_IDLE_CODE = 5'h15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/lvds_lane_scheduler_if.sv
// Requester-side and serializer-side handshake bundle of the lane scheduler;
// master is the scheduler, slave is whatever sits around it.
interface lvds_lane_scheduler_if #(
  parameter int N_REQ     = 4,
  parameter int PAYLOAD_W = 5
);
  logic [N_REQ-1:0]           req_valid;
  logic [N_REQ*PAYLOAD_W-1:0] req_data;
  logic [N_REQ-1:0]           req_ready;
  logic                       word_valid;
  logic [PAYLOAD_W:0]         word_data;
  logic                       word_ready;

  modport master (
    input  req_valid, req_data, word_ready,
    output req_ready, word_valid, word_data
  );

  modport slave (
    output req_valid, req_data, word_ready,
    input  req_ready, word_valid, word_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping; purely
// combinational, zero latency, no backpressure of its own.
module rr_arbiter
  import lvds_sched_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int PW    = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    idx,
  output logic             any_valid
);

  int cand;

  always_comb begin
    grant     = '0;
    idx       = '0;
    any_valid = 1'b0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr) + k) % N_REQ;
      if (!any_valid && req[PW'(cand)]) begin
        any_valid = 1'b1;
        idx       = PW'(cand);
      end
    end
    if (any_valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/lvds_lane_scheduler.sv
// Frames N_REQ payload streams onto one LVDS lane word: header then round-robin data slots.
// Latency 1 cycle request->word_valid; the output register stalls on !word_ready and no grant is issued while it stalls.
module lvds_lane_scheduler
  import lvds_sched_pkg::*;
#(
  parameter int                   N_REQ     = 4,
  parameter int                   PAYLOAD_W = 5,
  parameter int                   FRAME_LEN = 8,
  parameter logic [PAYLOAD_W-1:0] IDLE_CODE = PAYLOAD_W'(DEF_IDLE_CODE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  lvds_lane_scheduler_if.master bus,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int PW = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ);
  localparam int SW = (clog2(FRAME_LEN) < 1) ? 1 : clog2(FRAME_LEN);
  localparam logic [SW-1:0] LAST_SLOT = SW'(FRAME_LEN - 1);

  state_t               state, state_nxt;
  logic [SW-1:0]        slot_cnt, slot_nxt;
  logic [PAYLOAD_W-1:0] seq_cnt, seq_nxt;
  logic [PW-1:0]        rr_ptr, ptr_nxt;
  logic                 word_valid_q;
  logic [PAYLOAD_W:0]   word_data_q;

  logic                 load, ld, hdr, ld_mark;
  logic [PAYLOAD_W-1:0] ld_pay, sel_dat;
  logic [N_REQ-1:0]     grant, req_rdy;
  logic [PW-1:0]        gidx;
  logic                 any_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (bus.req_valid),
    .ptr       (rr_ptr),
    .grant     (grant),
    .idx       (gidx),
    .any_valid (any_valid)
  );

  assign load    = !word_valid_q || bus.word_ready;
  assign sel_dat = bus.req_data[int'(gidx)*PAYLOAD_W +: PAYLOAD_W];

  always_comb begin
    state_nxt  = state;
    slot_nxt   = slot_cnt;
    seq_nxt    = seq_cnt;
    ptr_nxt    = rr_ptr;
    ld         = 1'b0;
    hdr        = 1'b0;
    ld_pay     = '0;
    ld_mark    = 1'b0;
    req_rdy    = '0;
    frame_done = 1'b0;
    unique case (state)
      IDLE: hdr = enable && load;
      DATA: begin
        if (load) begin
          ld       = 1'b1;
          slot_nxt = slot_cnt + SW'(1);
          if (any_valid) begin
            ld_pay  = sel_dat;
            req_rdy = grant;
            ptr_nxt = (gidx == PW'(N_REQ - 1)) ? '0 : gidx + PW'(1);
          end else begin
            ld_pay = IDLE_CODE;
          end
          if (slot_cnt + SW'(1) == LAST_SLOT) state_nxt = LAST;
        end
      end
      LAST: begin
        // The final word retiring and the next header loading share one cycle.
        if (word_valid_q && bus.word_ready) begin
          frame_done = 1'b1;
          hdr        = enable;
          if (!enable) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (hdr) begin
      ld        = 1'b1;
      ld_pay    = seq_cnt;
      ld_mark   = 1'b1;
      seq_nxt   = seq_cnt + PAYLOAD_W'(1);
      slot_nxt  = '0;
      state_nxt = DATA;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      slot_cnt     <= '0;
      seq_cnt      <= '0;
      rr_ptr       <= '0;
      word_valid_q <= 1'b0;
      word_data_q  <= '0;
    end else begin
      state    <= state_nxt;
      slot_cnt <= slot_nxt;
      seq_cnt  <= seq_nxt;
      rr_ptr   <= ptr_nxt;
      if (ld) begin
        word_valid_q <= 1'b1;
        word_data_q  <= {ld_pay, ld_mark};
      end else if (bus.word_ready) begin
        word_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req_ready  = req_rdy;
  assign bus.word_valid = word_valid_q;
  assign bus.word_data  = word_data_q;
  assign busy           = (state != IDLE);

endmodule

// File: tb/tb_lvds_lane_scheduler.sv
// Directed stimulus with scoreboard queues for lane words and grants of lvds_lane_scheduler.
module tb_lvds_lane_scheduler;

  typedef struct packed {
    logic [5:0] w;
    logic       fd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic frame_done;
  logic busy;

  lvds_lane_scheduler_if #(.N_REQ(4), .PAYLOAD_W(5)) bus ();

  lvds_lane_scheduler #(
    .N_REQ(4), .PAYLOAD_W(5), .FRAME_LEN(8), .IDLE_CODE(5'h15)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .bus        (bus),
    .frame_done (frame_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  exp_t       exp_q[$];
  logic [3:0] rdy_q[$];
  int vec     = 0;
  int errs    = 0;
  int acc_cnt = 0;
  int tgt     = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [5:0] w, input logic fd);
    exp_t e;
    e.w  = w;
    e.fd = fd;
    exp_q.push_back(e);
  endtask

  task automatic push_idle_frame(input logic [4:0] seq);
    push_word({seq, 1'b1}, 1'b0);
    for (int k = 0; k < 7; k++) push_word(6'h2A, k == 6);
  endtask

  task automatic wait_acc(input int n);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      @(posedge clk);
      #1;
      if (acc_cnt >= n) done = 1'b1;
    end
    if (!done) begin
      vec++;
      errs++;
      $error("FAIL wait_accept observed=%0d expected=%0d", acc_cnt, n);
    end
  endtask

  // Scoreboard side: every accepted word and every grant is matched in order.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.word_valid && bus.word_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          vec++;
          errs++;
          $error("FAIL word_underflow observed=%0h expected=none", bus.word_data);
        end else begin
          e = exp_q.pop_front();
          chk("word_data", 32'(bus.word_data), 32'(e.w));
          chk("frame_done", 32'(frame_done), 32'(e.fd));
        end
      end else begin
        chk("frame_done_quiet", 32'(frame_done), 32'd0);
      end
      if (bus.word_valid && !bus.word_ready)
        chk("req_ready_stalled", 32'(bus.req_ready), 32'd0);
      if (bus.req_ready != 4'd0) begin
        if (rdy_q.size() == 0) begin
          vec++;
          errs++;
          $error("FAIL grant_underflow observed=%0h expected=none", bus.req_ready);
        end else begin
          chk("req_ready", 32'(bus.req_ready), 32'(rdy_q.pop_front()));
        end
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    bus.req_valid  = 4'd0;
    bus.req_data   = '0;
    bus.word_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_word_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_word_data", 32'(bus.word_data), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle fill, two frames back-to-back
    push_idle_frame(5'd0);
    push_idle_frame(5'd1);
    enable         = 1'b1;
    bus.word_ready = 1'b1;
    wait_acc(tgt + 9);
    enable = 1'b0;
    wait_acc(tgt + 16);
    tgt += 16;
    chk("t1_busy", 32'(busy), 32'd0);
    chk("t1_word_valid", 32'(bus.word_valid), 32'd0);

    // All requesters valid, round robin from pointer 0
    bus.req_valid = 4'hF;
    bus.req_data  = {5'd4, 5'd3, 5'd2, 5'd1};
    push_word({5'd2, 1'b1}, 1'b0);
    for (int k = 0; k < 7; k++) begin
      push_word({5'((k % 4) + 1), 1'b0}, k == 6);
      rdy_q.push_back(4'(1 << (k % 4)));
    end
    enable = 1'b1;
    wait_acc(tgt + 1);
    enable = 1'b0;
    wait_acc(tgt + 8);
    tgt += 8;

    // Backpressure mid-frame, pointer now 3
    bus.req_data = {5'h13, 5'h12, 5'h11, 5'h10};
    push_word({5'd3, 1'b1}, 1'b0);
    for (int k = 0; k < 7; k++) begin
      push_word({5'(5'h10 + ((3 + k) % 4)), 1'b0}, k == 6);
      rdy_q.push_back(4'(1 << ((3 + k) % 4)));
    end
    enable = 1'b1;
    wait_acc(tgt + 1);
    enable = 1'b0;
    wait_acc(tgt + 3);
    bus.word_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #2;
      chk("t3_hold_valid", 32'(bus.word_valid), 32'd1);
      chk("t3_hold_data", 32'(bus.word_data), 32'h22);
      chk("t3_hold_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.word_ready = 1'b1;
    wait_acc(tgt + 8);
    tgt += 8;

    // Enable drops at slot 3; frame still completes
    bus.req_valid = 4'd0;
    push_idle_frame(5'd4);
    enable = 1'b1;
    wait_acc(tgt + 4);
    enable = 1'b0;
    wait_acc(tgt + 8);
    tgt += 8;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_word_valid", 32'(bus.word_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_no_extra_words", 32'(acc_cnt), 32'(tgt));

    // Asynchronous reset at slot 5
    push_idle_frame(5'd5);
    enable = 1'b1;
    wait_acc(tgt + 5);
    tgt += 5;
    #2;
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    #1;
    chk("t5_word_valid", 32'(bus.word_valid), 32'd0);
    chk("t5_word_data", 32'(bus.word_data), 32'd0);
    chk("t5_req_ready", 32'(bus.req_ready), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_frame_done", 32'(frame_done), 32'd0);
    exp_q.delete();
    rdy_q.delete();
    @(posedge clk);
    #1;
    bus.req_valid = 4'b0100;
    bus.req_data  = {5'd0, 5'h0A, 5'd0, 5'd0};
    push_word({5'd0, 1'b1}, 1'b0);
    for (int k = 0; k < 7; k++) begin
      push_word(6'h14, k == 6);
      rdy_q.push_back(4'b0100);
    end
    rst_n = 1'b1;
    wait_acc(tgt + 1);
    enable = 1'b0;
    wait_acc(tgt + 8);
    tgt += 8;

    // 32 back-to-back frames: sequence number wraps 31 -> 0
    bus.req_valid = 4'd0;
    for (int f = 0; f < 32; f++) push_idle_frame(5'(1 + f));
    enable = 1'b1;
    wait_acc(tgt + 31 * 8 + 1);
    enable = 1'b0;
    wait_acc(tgt + 256);
    tgt += 256;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_word_valid", 32'(bus.word_valid), 32'd0);
    chk("sb_leftover_words", 32'(exp_q.size()), 32'd0);
    chk("sb_leftover_grants", 32'(rdy_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
